// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave exposing a small 32-bit register file.
// Register 0 is a read-only ID word; each access takes WAIT_STATES+1 cycles to terminate.
//
// state  | meaning
// IDLE   | waiting for cyc & stb, request latched on entry to WAIT/RESP
// WAIT   | down-counter running toward the response; cyc low aborts
// RESP   | single cycle with ack or err asserted, write committed at its end
module wb_slave_regfile #(
    parameter int          dw          = 32,
    parameter int          aw          = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hCAFE0001
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int          IW      = $clog2(NUM_REGS);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_RESP  = 2'd2;
    localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [aw-1:0] adr_q;
    logic [dw-1:0] dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [31:0]   regs [NUM_REGS];

    logic          start;
    logic          enter_resp;
    logic [aw-1:0] src_adr;
    logic          src_we;
    logic [IW-1:0] src_idx;
    logic          src_ok;
    logic [31:0]   rd_word;
    logic          unused_inputs;

    assign wb_rty_o      = 1'b0;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i};

    // With zero wait states the response is built straight from the bus,
    // before the request registers have been loaded.
    always_comb begin
        start      = (state == S_IDLE) && wb_cyc_i && wb_stb_i;
        src_adr    = (state == S_IDLE) ? wb_adr_i : adr_q;
        src_we     = (state == S_IDLE) ? wb_we_i  : we_q;
        src_idx    = src_adr[IW+1:2];
        src_ok     = (src_adr[1:0] == 2'b00) && ((src_adr >> (IW + 2)) == '0);
        enter_resp = (start && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && wb_cyc_i && (cnt == 4'd0));
        rd_word    = (src_idx == '0) ? ID_VALUE : regs[src_idx];
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= 4'd0;
            we_q     <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        adr_q <= wb_adr_i;
                        dat_q <= wb_dat_i;
                        sel_q <= wb_sel_i;
                        we_q  <= wb_we_i;
                        cnt   <= WS_LOAD;
                        state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (src_we && src_ok && (src_idx != '0)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (sel_q[b]) begin
                                regs[src_idx][8*b +: 8] <= dat_q[8*b +: 8];
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enter_resp) begin
                if (src_ok) begin
                    wb_ack_o <= 1'b1;
                    if (!src_we) begin
                        wb_dat_o <= rd_word;
                    end
                end else begin
                    wb_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Randomized self-checking bench for wb_slave_regfile against a register-array model.
// Instance 0 uses one wait state, instance 1 uses none.
module tb_wb_slave_regfile;

    localparam logic [31:0] ID = 32'hCAFE0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic [3:0]  sel [2];
    logic        ack [2];
    logic        err [2];
    logic        rty [2];
    logic [2:0]  cti = 3'b111;
    logic [1:0]  bte = 2'b01;

    logic [31:0] m0 [16];
    logic [31:0] m1 [16];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          rty_bad = 0;

    always #5 clk = ~clk;

    wb_slave_regfile #(.WAIT_STATES(1)) dut0 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]),
        .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r[0]), .wb_ack_o(ack[0]),
        .wb_err_o(err[0]), .wb_rty_o(rty[0])
    );

    wb_slave_regfile #(.WAIT_STATES(0)) dut1 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]),
        .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r[1]), .wb_ack_o(ack[1]),
        .wb_err_o(err[1]), .wb_rty_o(rty[1])
    );

    always @(negedge clk) begin
        if (rty[0] !== 1'b0 || rty[1] !== 1'b0) rty_bad = 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            m0[i] = 32'd0;
            m1[i] = 32'd0;
        end
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic wr);
        cyc[w] = 1'b1; stb[w] = 1'b1; adr[w] = a; dat_w[w] = d; sel[w] = s; we[w] = wr;
    endtask

    task automatic release_bus(input int w);
        cyc[w] = 1'b0; stb[w] = 1'b0;
    endtask

    // One classic transfer; expectation derived from address rules and the model arrays.
    task automatic xfer(input int w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic wr, input bit drop_stb,
                        output logic [31:0] rd);
        int          n;
        bit          done;
        logic        ok;
        logic [3:0]  idx;
        logic [31:0] exp_d;
        logic [31:0] cur;
        ok    = (a[1:0] == 2'b00) && ((a >> 6) == 32'd0);
        idx   = a[5:2];
        cur   = (w == 0) ? m0[idx] : m1[idx];
        exp_d = 32'd0;
        if (ok && !wr) exp_d = (idx == 4'd0) ? ID : cur;
        @(negedge clk);
        drive(w, a, d, s, wr);
        n = 0;
        done = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[w] || err[w]) done = 1;
            else begin
                chk("dat_idle", dat_r[w], 32'd0);
                if (drop_stb && n == 1) stb[w] = 1'b0;
            end
        end
        chk("latency", n, (w == 0) ? 32'd2 : 32'd1);
        chk("ack", {31'd0, ack[w]}, {31'd0, ok});
        chk("err", {31'd0, err[w]}, {31'd0, !ok});
        chk("rdata", dat_r[w], exp_d);
        rd = dat_r[w];
        release_bus(w);
        if (ok && wr && idx != 4'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            end
            if (w == 0) m0[idx] = cur; else m1[idx] = cur;
        end
        @(negedge clk);
        chk("term_pulse", {31'd0, ack[w] | err[w]}, 32'd0);
    endtask

    function automatic logic [31:0] rand_adr();
        int r;
        logic [31:0] base;
        r = $urandom_range(0, 9);
        base = 32'($urandom_range(0, 15)) << 2;
        if (r < 7)       return base;
        else if (r == 7) return base + 32'($urandom_range(1, 3));
        else if (r == 8) return ($urandom & 32'hFFFF_FFFC) | 32'h40;
        else             return base | 32'h8000_0000;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  ack_mask;
        for (int w = 0; w < 2; w++) begin
            cyc[w] = 0; stb[w] = 0; we[w] = 0; adr[w] = 0; dat_w[w] = 0; sel[w] = 0;
        end
        clear_models();

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack[0]}, 32'd0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        chk("rst_dat", dat_r[0], 32'd0);
        rst = 1'b0;

        xfer(0, 32'h0, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("id_read", rd, ID);

        xfer(0, 32'h8, 32'h11223344, 4'hF, 1'b1, 0, rd);
        xfer(0, 32'h8, 32'hAABBCCDD, 4'h5, 1'b1, 0, rd);
        xfer(0, 32'h8, 32'h0, 4'h1, 1'b0, 0, rd);
        chk("sel_merge", rd, 32'h11BB33DD);

        xfer(0, 32'h40, 32'h0, 4'hF, 1'b0, 0, rd);
        xfer(0, 32'h6, 32'h0, 4'hF, 1'b0, 0, rd);
        xfer(0, 32'h4, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("reg1_zero", rd, 32'd0);

        // cyc dropped during WAIT must abort silently
        @(negedge clk);
        drive(0, 32'hC, 32'h5A5A5A5A, 4'hF, 1'b1);
        @(negedge clk);
        release_bus(0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_term", {31'd0, ack[0] | err[0]}, 32'd0);
        end
        xfer(0, 32'hC, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("abort_nowrite", rd, 32'd0);

        // strobe held: three back-to-back writes, ack every third cycle
        @(negedge clk);
        drive(0, 32'hC, 32'h0BADF00D, 4'hF, 1'b1);
        ack_mask = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ack_mask[k-1] = ack[0];
        end
        release_bus(0);
        m0[3] = 32'h0BADF00D;
        chk("b2b_acks", {24'd0, ack_mask}, 32'h92);
        @(negedge clk);
        xfer(0, 32'hC, 32'h0, 4'hF, 1'b0, 0, rd);

        // stb without cyc is not a transfer
        @(negedge clk);
        stb[0] = 1'b1; adr[0] = 32'h0; we[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stb_nocyc", {31'd0, ack[0] | err[0]}, 32'd0);
        end
        stb[0] = 1'b0;

        // stb dropped in WAIT with cyc high still completes
        xfer(0, 32'h10, 32'hDEAD0010, 4'hF, 1'b1, 1, rd);
        xfer(0, 32'h10, 32'h0, 4'hF, 1'b0, 0, rd);

        // reset during the RESP cycle of a write
        @(negedge clk);
        drive(0, 32'h4, 32'hFFFFFFFF, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("resp_before_rst", {31'd0, ack[0]}, 32'd1);
        rst = 1'b1;
        release_bus(0);
        @(negedge clk);
        chk("rst_kills_ack", {31'd0, ack[0]}, 32'd0);
        rst = 1'b0;
        clear_models();
        @(negedge clk);
        chk("post_rst_ack", {31'd0, ack[0]}, 32'd0);
        xfer(0, 32'h4, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("rst_lost_write", rd, 32'd0);
        xfer(0, 32'h0, 32'h12345678, 4'hF, 1'b1, 0, rd);
        xfer(0, 32'h0, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("id_readonly", rd, ID);

        for (int i = 0; i < 60; i++) begin
            xfer(0, rand_adr(), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 0, rd);
        end

        xfer(1, 32'h0, 32'h0, 4'hF, 1'b0, 0, rd);
        chk("ws0_id", rd, ID);
        for (int i = 0; i < 30; i++) begin
            xfer(1, rand_adr(), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 0, rd);
        end

        chk("rty_zero", {31'd0, rty_bad}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_slave_regfile.md
WB_SLAVE_REGFILE -- requirements
Module: wb_slave_regfile

Interface
REQ-001 The block SHALL have parameter dw, default 32, Wishbone data width (only 32 supported).
REQ-002 The block SHALL have parameter aw, default 32, Wishbone address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-004 The block SHALL have parameter WAIT_STATES, default 1, cycles inserted between strobe sample and ack (0..15).
REQ-005 The block SHALL have parameter ID_VALUE, default 32'hCAFE0001, read-only content of register 0.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset:
- wb_clk  in  1  clock, all logic on rising edge.
- wb_rst  in  1  synchronous active-high reset.
- wb_adr_i  in  aw  byte address.
- wb_dat_i  in  dw  write data.
- wb_sel_i  in  4  byte enables; bit n = byte lane n.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  transfer strobe.
- wb_cti_i  in  3  cycle type; ignored, every access classic.
- wb_bte_i  in  2  burst type; ignored.
- wb_dat_o  out  dw  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry; constant 0.

Function
REQ-007 The block SHALL run FSM states IDLE, WAIT, RESP.
REQ-008 In IDLE, when wb_cyc_i & wb_stb_i are both 1, the block SHALL latch adr/dat/sel/we and go to WAIT, or to RESP if WAIT_STATES=0.
REQ-009 In WAIT, a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-010 Access latency SHALL be exactly WAIT_STATES+1 cycles from the cycle stb is sampled in IDLE to the cycle ack/err is high.
REQ-011 RESP SHALL last exactly one cycle, asserting either wb_ack_o or wb_err_o (never both), then return to IDLE unconditionally.
REQ-012 A strobe still high in the cycle after RESP SHALL be sampled in IDLE as a new transfer; back-to-back transfers take WAIT_STATES+2 cycles each.
REQ-013 Decode: word index = latched adr[log2(NUM_REGS)+1:2]; an access SHALL error if adr[1:0]!=0 or adr[aw-1:log2(NUM_REGS)+2]!=0.
REQ-014 On a decoded write, each register byte with sel bit 1 SHALL take the latched data on the RESP clock edge; bytes with sel 0 SHALL stay unchanged.
REQ-015 Writes to register 0 SHALL be acked and discarded.
REQ-016 On a decoded read, wb_dat_o SHALL hold the full 32-bit register (all lanes, regardless of sel) during RESP; register 0 reads ID_VALUE.
REQ-017 wb_dat_o SHALL be 0 in every cycle other than a read-ack RESP cycle, including error responses.
REQ-018 An errored access SHALL NOT modify any register.
REQ-019 If wb_cyc_i is 0 in any WAIT cycle, the FSM SHALL abort to IDLE next edge: no ack, no err, no write.
REQ-020 A stb drop with cyc high during WAIT SHALL be ignored; the access SHALL complete.
REQ-021 wb_stb_i without wb_cyc_i SHALL be ignored in IDLE.
REQ-022 wb_ack_o, wb_err_o and wb_dat_o SHALL be registered outputs.

Reset
REQ-023 When wb_rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear. wb_ack_o, wb_err_o, wb_dat_o and registers 1..NUM_REGS-1 SHALL become 0.
REQ-024 Reset SHALL take priority over all other activity, including a pending write in WAIT or RESP; that write is lost and no ack is issued.
REQ-025 wb_rty_o SHALL be 0 at all times, including during reset.

Verification
REQ-026 Reset, read adr 0x0 -> ack 2 cycles after stb sampled (WAIT_STATES=1), dat_o=0xCAFE0001, err=0.
REQ-027 Write 0x8 dat 0x11223344 sel 0xF, then write 0x8 dat 0xAABBCCDD sel 0x5, read 0x8 -> 0x11BB33DD.
REQ-028 Read 0x40 (out of range, NUM_REGS=16) and read 0x6 (misaligned) -> err one cycle each, ack=0, dat_o=0. Following read of 0x4 -> 0x0.
REQ-029 Write 0xC, drop cyc in WAIT -> no ack/err, read 0xC -> 0x0. Write 0xC again with stb held 3 back-to-back accesses -> one ack every 3 cycles.
REQ-030 Write 0x4 dat 0xFFFFFFFF, assert wb_rst in the RESP cycle -> no ack after reset, read 0x4 -> 0x0. Write 0x0 dat 0x12345678 -> ack, read 0x0 -> 0xCAFE0001.
REQ-031 WAIT_STATES=0 build: read 0x0 -> ack in cycle immediately after stb sampled; wb_rty_o=0 throughout all scenarios.
